// File: rtl/regfile_sb.sv
// Integer register file (2 async read, 2 sync write ports) with a pending late-write scoreboard.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_sb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rd1_data,
    output logic [XLEN-1:0] o_rd2_data,
    output logic            o_rs1_busy,
    output logic            o_rs2_busy,
    input  logic            i_we_a,
    input  logic [AW-1:0]   i_wa_addr,
    input  logic [XLEN-1:0] i_wa_data,
    input  logic            i_we_b,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_issue_valid,
    input  logic [AW-1:0]   i_issue_rd,
    output logic            o_hazard
);

    logic [NREG-1:0][XLEN-1:0] r_regs;
    logic [NREG-1:0]           r_busy;
    logic [NREG-1:0]           w_busy_next;
    logic                      w_wa_en;
    logic                      w_wb_en;

    assign w_wa_en = i_we_a && (i_wa_addr != '0);
    assign w_wb_en = i_we_b && (i_wb_addr != '0);

    // Set after clear so a fresh issue replaces the retiring late op.
    always_comb begin
        w_busy_next = r_busy;
        for (int r = 1; r < int'(NREG); r++) begin
            if (i_we_b && (i_wb_addr == AW'(r))) begin
                w_busy_next[r] = 1'b0;
            end
            if (i_issue_valid && (i_issue_rd == AW'(r))) begin
                w_busy_next[r] = 1'b1;
            end
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regs <= '0;
            r_busy <= '0;
        end else begin
            if (w_wa_en) begin
                r_regs[i_wa_addr] <= i_wa_data;
            end
            if (w_wb_en) begin
                r_regs[i_wb_addr] <= i_wb_data;
            end
            r_busy <= w_busy_next;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_rs1_clr;
    logic w_rs2_clr;

    assign w_rs1_clr = w_wb_en && (i_wb_addr == i_rs1_addr)
                       && !(i_issue_valid && (i_issue_rd == i_rs1_addr));
    assign w_rs2_clr = w_wb_en && (i_wb_addr == i_rs2_addr)
                       && !(i_issue_valid && (i_issue_rd == i_rs2_addr));

    always_comb begin
        o_rd1_data = r_regs[i_rs1_addr];
        if (w_wb_en && (i_wb_addr == i_rs1_addr)) begin
            o_rd1_data = i_wb_data;
        end else if (w_wa_en && (i_wa_addr == i_rs1_addr)) begin
            o_rd1_data = i_wa_data;
        end
    end

    always_comb begin
        o_rd2_data = r_regs[i_rs2_addr];
        if (w_wb_en && (i_wb_addr == i_rs2_addr)) begin
            o_rd2_data = i_wb_data;
        end else if (w_wa_en && (i_wa_addr == i_rs2_addr)) begin
            o_rd2_data = i_wa_data;
        end
    end

    assign o_rs1_busy = r_busy[i_rs1_addr] && !w_rs1_clr;
    assign o_rs2_busy = r_busy[i_rs2_addr] && !w_rs2_clr;
`else
    assign o_rd1_data = r_regs[i_rs1_addr];
    assign o_rd2_data = r_regs[i_rs2_addr];
    assign o_rs1_busy = r_busy[i_rs1_addr];
    assign o_rs2_busy = r_busy[i_rs2_addr];
`endif

    assign o_hazard = o_rs1_busy || o_rs2_busy || (i_issue_valid && r_busy[i_issue_rd]);

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised self-checking bench for regfile_sb against an array-based reference model.
// Follows the RTL configuration through REGFILE_BYPASS_EN.
module tb_regfile_sb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   rs1_addr, rs2_addr, wa_addr, wb_addr, issue_rd;
    logic [XLEN-1:0] rd1_data, rd2_data, wa_data, wb_data;
    logic            rs1_busy, rs2_busy, we_a, we_b, issue_valid, hazard;

    logic [XLEN-1:0] m_regs [NREG];
    logic            m_busy [NREG];
    int              n_checks = 0;
    int              n_fail   = 0;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rs1_addr   (rs1_addr),
        .i_rs2_addr   (rs2_addr),
        .o_rd1_data   (rd1_data),
        .o_rd2_data   (rd2_data),
        .o_rs1_busy   (rs1_busy),
        .o_rs2_busy   (rs2_busy),
        .i_we_a       (we_a),
        .i_wa_addr    (wa_addr),
        .i_wa_data    (wa_data),
        .i_we_b       (we_b),
        .i_wb_addr    (wb_addr),
        .i_wb_data    (wb_data),
        .i_issue_valid(issue_valid),
        .i_issue_rd   (issue_rd),
        .o_hazard     (hazard)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        exp_rd = m_regs[a];
`ifdef REGFILE_BYPASS_EN
        if (a != 0 && we_a && wa_addr == a) exp_rd = wa_data;
        if (a != 0 && we_b && wb_addr == a) exp_rd = wb_data;
`endif
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        exp_busy = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (a != 0 && we_b && wb_addr == a && !(issue_valid && issue_rd == a)) exp_busy = 1'b0;
`endif
    endfunction

    function automatic logic exp_hazard();
        exp_hazard = exp_busy(rs1_addr) | exp_busy(rs2_addr) | (issue_valid & m_busy[issue_rd]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(NREG); i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Apply one clock edge to the model, then let the DUT take the same edge.
    task automatic tick();
        if (we_a && wa_addr != 0) m_regs[wa_addr] = wa_data;
        if (we_b && wb_addr != 0) m_regs[wb_addr] = wb_data;
        if (we_b) m_busy[wb_addr] = 1'b0;
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = 0; we_b = 0; issue_valid = 0;
        wa_addr = 0; wb_addr = 0; issue_rd = 0; wa_data = 0; wb_data = 0;
    endtask

    task automatic test_reset();
        idle();
        rs1_addr = 0; rs2_addr = 0;
        reset = 1'b0;
        model_clear();
        #1;
        for (int a = 0; a < int'(NREG); a += 9) begin
            rs1_addr = AW'(a); rs2_addr = AW'(a + 4);
            #1;
            n_checks++;
            if (rd1_data !== 0 || rd2_data !== 0 || rs1_busy !== 0 || rs2_busy !== 0) begin
                n_fail++;
                $display("FAIL reset_state a=%0d: rd1=%h rd2=%h b1=%b b2=%b, want all 0",
                         a, rd1_data, rd2_data, rs1_busy, rs2_busy);
            end
        end
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_port_a_write();
        idle();
        we_a = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
        tick();
        idle();
        rs1_addr = 5;
        #1;
        n_checks++;
        if (rd1_data !== 32'hDEADBEEF || rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL port_a_write: rd1=%h busy=%b, want deadbeef/0", rd1_data, rs1_busy);
        end
    endtask

    task automatic test_x0();
        idle();
        we_a = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF;
        issue_valid = 1; issue_rd = 0;
        tick();
        idle();
        rs1_addr = 0; rs2_addr = 0;
        issue_valid = 1; issue_rd = 0;
        #1;
        n_checks++;
        if (rd1_data !== 0 || rs1_busy !== 0 || rs2_busy !== 0 || hazard !== 0) begin
            n_fail++;
            $display("FAIL x0_hardwired: rd=%h busy=%b hz=%b, want 0/0/0", rd1_data, rs1_busy,
                     hazard);
        end
        idle();
    endtask

    task automatic test_issue_clear();
        idle();
        rs1_addr = 0;
        issue_valid = 1; issue_rd = 7;
        tick();
        idle();
        rs2_addr = 7;
        #1;
        n_checks++;
        if (rs2_busy !== 1'b1 || hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_busy: busy=%b hz=%b, want 1/1", rs2_busy, hazard);
        end
        we_b = 1; wb_addr = 7; wb_data = 32'h1234;
        #1;
        n_checks++;
`ifdef REGFILE_BYPASS_EN
        if (rd2_data !== 32'h1234 || hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_same_cycle: rd2=%h hz=%b, want 1234/0", rd2_data, hazard);
        end
`else
        if (rd2_data !== m_regs[7] || hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL wb_same_cycle: rd2=%h hz=%b, want %h/1", rd2_data, hazard, m_regs[7]);
        end
`endif
        tick();
        idle();
        #1;
        n_checks++;
        if (rd2_data !== 32'h1234 || rs2_busy !== 1'b0 || hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_clear: rd2=%h busy=%b hz=%b, want 1234/0/0", rd2_data, rs2_busy,
                     hazard);
        end
    endtask

    task automatic test_same_addr();
        idle();
        we_a = 1; wa_addr = 9; wa_data = 32'hA;
        we_b = 1; wb_addr = 9; wb_data = 32'hB;
        tick();
        idle();
        rs1_addr = 9;
        #1;
        n_checks++;
        if (rd1_data !== 32'hB) begin
            n_fail++;
            $display("FAIL dual_write_x9: rd1=%h, want 0000000b", rd1_data);
        end
    endtask

    task automatic test_waw();
        idle();
        issue_valid = 1; issue_rd = 3;
        tick();
        idle();
        rs1_addr = 0; rs2_addr = 0;
        issue_valid = 1; issue_rd = 3;
        we_b = 1; wb_addr = 3; wb_data = 32'h33;
        #1;
        n_checks++;
        if (hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_hazard: hz=%b, want 1", hazard);
        end
        tick();
        idle();
        rs1_addr = 3;
        #1;
        n_checks++;
        if (rs1_busy !== 1'b1 || rd1_data !== 32'h33) begin
            n_fail++;
            $display("FAIL waw_set_wins: busy=%b rd1=%h, want 1/00000033", rs1_busy, rd1_data);
        end
    endtask

    task automatic test_async_reset();
        idle();
        issue_valid = 1; issue_rd = 4;
        tick();
        issue_rd = 6;
        tick();
        idle();
        we_a = 1; wa_addr = 4; wa_data = 32'h55;
        tick();
        idle();
        rs1_addr = 4; rs2_addr = 6;
        #1;
        n_checks++;
        if (rd1_data !== 32'h55 || rs1_busy !== 1 || rs2_busy !== 1) begin
            n_fail++;
            $display("FAIL pre_reset: rd1=%h b1=%b b2=%b, want 55/1/1", rd1_data, rs1_busy,
                     rs2_busy);
        end
        issue_valid = 1; issue_rd = 4;
        #1;
        reset = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (rd1_data !== 0 || rd2_data !== 0 || rs1_busy !== 0 || rs2_busy !== 0
            || hazard !== 0) begin
            n_fail++;
            $display("FAIL mid_reset: rd1=%h rd2=%h b1=%b b2=%b hz=%b, want all 0", rd1_data,
                     rd2_data, rs1_busy, rs2_busy, hazard);
        end
        idle();
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        we_b = 1; wb_addr = 4; wb_data = 32'h77;
        tick();
        idle();
        #1;
        n_checks++;
        if (rs1_busy !== 1'b0 || rd1_data !== 32'h77) begin
            n_fail++;
            $display("FAIL post_reset_wb: busy=%b rd1=%h, want 0/00000077", rs1_busy, rd1_data);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            rs1_addr    = AW'($urandom_range(0, 7));
            rs2_addr    = AW'($urandom_range(0, 7));
            we_a        = 1'($urandom_range(0, 1));
            wa_addr     = AW'($urandom_range(0, 7));
            wa_data     = $urandom;
            we_b        = ($urandom_range(0, 2) == 0);
            wb_addr     = AW'($urandom_range(0, 7));
            wb_data     = $urandom;
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = AW'($urandom_range(0, 7));
            #1;
            n_checks++;
            if (rd1_data !== exp_rd(rs1_addr) || rd2_data !== exp_rd(rs2_addr)
                || rs1_busy !== exp_busy(rs1_addr) || rs2_busy !== exp_busy(rs2_addr)
                || hazard !== exp_hazard()) begin
                n_fail++;
                $display("FAIL random it=%0d: rd1=%h/%h rd2=%h/%h b1=%b/%b b2=%b/%b hz=%b/%b",
                         it, rd1_data, exp_rd(rs1_addr), rd2_data, exp_rd(rs2_addr), rs1_busy,
                         exp_busy(rs1_addr), rs2_busy, exp_busy(rs2_addr), hazard, exp_hazard());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        rs1_addr = 0; rs2_addr = 0;
        model_clear();
        #1;
        test_reset();
        test_port_a_write();
        test_x0();
        test_issue_clear();
        test_same_addr();
        test_waw();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a pending-write scoreboard for the RISC-V core. It provides two asynchronous read ports and two synchronous write ports: port A for the single-cycle ALU writeback and port B for late writeback from load or multi-cycle units. Per-register busy bits track destinations whose late result is still outstanding, so the control path can stall on RAW and WAW hazards. It replaces the fixed 32×32, single-write register file in the datapath.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥2)
- AW, $clog2(NREG), register address width (derived, do not override)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- rs1_addr, rs2_addr  in  AW  read addresses
- rd1_data, rd2_data  out  XLEN  read data
- rs1_busy, rs2_busy  out  1  source register has a late write pending
- we_a  in  1  port A write enable
- wa_addr  in  AW  port A address
- wa_data  in  XLEN  port A data
- we_b  in  1  port B write enable; also clears the busy bit
- wb_addr  in  AW  port B address
- wb_data  in  XLEN  port B data
- issue_valid  in  1  mark issue_rd as pending a port-B write
- issue_rd  in  AW  destination being issued to a late unit
- hazard  out  1  rs1_busy | rs2_busy | (issue_valid & busy[issue_rd])

## Operation
- Register 0 always reads 0.
  - Writes to register 0 are ignored on both ports.
  - issue_rd = 0 never sets a busy bit.
- Reads are combinational: rdN_data = regs[rsN_addr] and rsN_busy = busy[rsN_addr].
- Writes commit on the rising edge of clk.
  - If we_a and we_b target the same nonzero address in one cycle, port B data wins.
  - A port A write to a busy register updates the data but leaves busy set.
- Scoreboard, per register r ≠ 0:
  - Set busy[r] on the edge where issue_valid & issue_rd == r.
  - Clear busy[r] on the edge where we_b & wb_addr == r.
  - If set and clear hit the same r in one cycle, set wins: a new pending op replaces the retiring one.
  - Issue to an already-busy r keeps busy set, and hazard is asserted that cycle (WAW).
  - we_b to a non-busy register writes the data and leaves busy at 0. This is not an error.
- hazard is purely combinational from the current state and inputs. The block itself never blocks issue; honouring hazard is the controller's job.

## Timing
- Reset asserted (reset = 0), taking effect immediately without a clock edge:
  - All registers go to 0 and all busy bits go to 0.
  - Therefore rd1_data = rd2_data = 0, rs1_busy = rs2_busy = 0, and hazard = issue_valid & 0 = 0.
- Reset asserted mid-operation discards all pending busy state. A late writeback arriving after reset release is an ordinary write and leaves busy at 0.
- Write latency is 1 cycle: data written on edge N is visible on the read ports after edge N.
- Busy set or clear is likewise visible after the edge.
- Without bypass, a same-cycle read of an address being written returns the old value.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-to-read forwarding is enabled.
  - If rsN_addr ≠ 0 matches an active write, rdN_data returns that write data. When both ports match, port B has priority.
  - If we_b matches rsN_addr, rsN_busy reads 0 in that cycle, unless an issue to the same register also happens that cycle.
  - hazard uses the forwarded busy values.
- REGFILE_BYPASS_EN undefined: reads and busy reflect register state only. There is no forwarding path, which gives a shorter critical path.

## Test plan
- Reset, then we_a wa_addr=5 wa_data=0xDEADBEEF; next cycle rs1_addr=5 → rd1_data=0xDEADBEEF, rs1_busy=0.
- we_a wa_addr=0 wa_data=0xFFFFFFFF, plus issue_rd=0 → rd of x0 = 0, busy[0] = 0, hazard = 0.
- issue_rd=7; next cycle rs2_addr=7 → rs2_busy=1, hazard=1; we_b wb_addr=7 wb_data=0x1234 → after the edge rd2_data=0x1234 and rs2_busy=0. With REGFILE_BYPASS_EN, rd2_data=0x1234 and hazard=0 already in the we_b cycle.
- Same edge: we_a and we_b both to x9, with wa_data=0xA and wb_data=0xB → x9 = 0xB.
- x3 busy; issue_rd=3 together with we_b wb_addr=3 → after the edge busy[3]=1, and hazard=1 during that cycle.
- Set busy on x4 and x6, write x4=0x55, then drive reset=0 between edges → all rd_data = 0 and all busy = 0 immediately; after reset release, we_b to x4 leaves busy[4] = 0.
